// File: rtl/load_store_unit.sv
// Load/store unit: turns datapath load/store requests into single word-aligned bus transactions with lane steering and extension.
// Latency: request in cycle N, bus_valid from N+1, result and stall release the cycle after bus_ready; minimum stall 2 cycles.
// Backpressure: stalls the datapath while waiting for bus_ready; gives up after TIMEOUT_CYCLES request cycles and flags bus_error.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [2:0]  format,
    output logic [31:0] data_fetched,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [3:0]  bus_byte_enable,
    output logic [31:0] bus_write_data,
    input  logic [31:0] bus_read_data
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQUEST, DONE} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [31:0]   rdata;
    logic [2:0]    req_fmt;
    logic [1:0]    req_lo;

    logic          access;
    logic          is_byte;
    logic          is_half;
    logic          mis_c;
    logic          accept;
    logic [3:0]    be_c;
    logic [31:0]   wd_c;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;

    // Formats 011/110/111 fall into the word case because only format[1:0] selects the size.
    assign access  = read_enable | write_enable;
    assign is_byte = (format[1:0] == 2'b00);
    assign is_half = (format[1:0] == 2'b01);
    assign mis_c   = (is_half & address[0]) | (format[1] & (address[1:0] != 2'b00));
    assign accept  = (state == IDLE) & access & ~mis_c;

    assign stall      = accept | (state == REQUEST);
    assign misaligned = (state == IDLE) & access & mis_c;

    always_comb begin
        be_c = 4'b1111;
        wd_c = write_data;
        if (is_byte) begin
            be_c = 4'b0001 << address[1:0];
            wd_c = {4{write_data[7:0]}};
        end else if (is_half) begin
            be_c = 4'b0011 << {address[1], 1'b0};
            wd_c = {2{write_data[15:0]}};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            count           <= '0;
            rdata           <= '0;
            req_fmt         <= '0;
            req_lo          <= '0;
            bus_valid       <= 1'b0;
            bus_write       <= 1'b0;
            bus_address     <= '0;
            bus_byte_enable <= '0;
            bus_write_data  <= '0;
            bus_error       <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state           <= REQUEST;
                        count           <= '0;
                        bus_valid       <= 1'b1;
                        bus_write       <= write_enable;
                        bus_address     <= {address[31:2], 2'b00};
                        bus_byte_enable <= be_c;
                        bus_write_data  <= wd_c;
                        req_fmt         <= format;
                        req_lo          <= address[1:0];
                    end
                end
                REQUEST: begin
                    if (bus_ready) begin
                        state     <= DONE;
                        bus_valid <= 1'b0;
                        if (!bus_write) rdata <= bus_read_data;
                    end else if (count == CW'(TIMEOUT_CYCLES - 1)) begin
                        // Abandon the access; the DONE cycle reports the error instead of data.
                        state     <= DONE;
                        bus_valid <= 1'b0;
                        bus_error <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (req_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = req_lo[1] ? rdata[31:16] : rdata[15:0];
        data_fetched = '0;
        if ((state == DONE) && !bus_error) begin
            case (req_fmt[1:0])
                2'b00:   data_fetched = {{24{~req_fmt[2] & lane_b[7]}}, lane_b};
                2'b01:   data_fetched = {{16{~req_fmt[2] & lane_h[15]}}, lane_h};
                default: data_fetched = rdata;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: lane steering, extension, misalignment, timeout and async reset.
module tb_load_store_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        read_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [2:0]  format = '0;
    logic [31:0] data_fetched;
    logic        stall;
    logic        misaligned;
    logic        bus_error;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data = '0;

    int vectors = 0;
    int miscompares = 0;
    int stall_cycles;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .read_enable(read_enable), .write_enable(write_enable),
        .address(address), .write_data(write_data), .format(format),
        .data_fetched(data_fetched), .stall(stall), .misaligned(misaligned),
        .bus_error(bus_error), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_write(bus_write), .bus_address(bus_address),
        .bus_byte_enable(bus_byte_enable), .bus_write_data(bus_write_data),
        .bus_read_data(bus_read_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        // Reset state
        step(); step(); #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_valid", 32'(bus_valid), 32'd0);
        chk("rst_write", 32'(bus_write), 32'd0);
        chk("rst_addr", bus_address, 32'h0);
        chk("rst_be", 32'(bus_byte_enable), 32'h0);
        chk("rst_wdata", bus_write_data, 32'h0);
        chk("rst_err", 32'(bus_error), 32'd0);
        chk("rst_data", data_fetched, 32'h0);

        // LB 0x103, two wait cycles
        step(); reset = 1'b1;
        read_enable = 1'b1; format = 3'b000; address = 32'h103; #1;
        stall_cycles = 0;
        chk("lb_req_stall", 32'(stall), 32'd1); stall_cycles += int'(stall);
        chk("lb_req_valid", 32'(bus_valid), 32'd0);
        step(); read_enable = 1'b0; address = 32'h0; #1;
        chk("lb_valid", 32'(bus_valid), 32'd1); stall_cycles += int'(stall);
        chk("lb_addr", bus_address, 32'h100);
        chk("lb_be", 32'(bus_byte_enable), 32'b1000);
        chk("lb_write", 32'(bus_write), 32'd0);
        step(); #1;
        chk("lb_wait_valid", 32'(bus_valid), 32'd1); stall_cycles += int'(stall);
        chk("lb_wait_addr", bus_address, 32'h100);
        step(); bus_ready = 1'b1; bus_read_data = 32'h80FF_1234; #1;
        stall_cycles += int'(stall);
        step(); bus_ready = 1'b0; bus_read_data = 32'h0; #1;
        chk("lb_done_stall", 32'(stall), 32'd0);
        chk("lb_done_valid", 32'(bus_valid), 32'd0);
        chk("lb_data", data_fetched, 32'hFFFF_FF80);
        chk("lb_done_err", 32'(bus_error), 32'd0);
        chk("lb_stall_cycles", 32'(stall_cycles), 32'd4);
        step(); #1;
        chk("lb_idle_data", data_fetched, 32'h0);

        // SH 0x202, immediate ready
        step(); write_enable = 1'b1; format = 3'b001; address = 32'h202; write_data = 32'h0000_BEEF; #1;
        stall_cycles = int'(stall);
        step(); write_enable = 1'b0; bus_ready = 1'b1; #1;
        stall_cycles += int'(stall);
        chk("sh_write", 32'(bus_write), 32'd1);
        chk("sh_addr", bus_address, 32'h200);
        chk("sh_be", 32'(bus_byte_enable), 32'b1100);
        chk("sh_wdata", bus_write_data, 32'hBEEF_BEEF);
        step(); bus_ready = 1'b0; #1;
        chk("sh_done_stall", 32'(stall), 32'd0);
        chk("sh_stall_cycles", 32'(stall_cycles), 32'd2);

        // LW misaligned at 0x301
        step(); read_enable = 1'b1; format = 3'b010; address = 32'h301; #1;
        chk("lw_mis", 32'(misaligned), 32'd1);
        chk("lw_mis_stall", 32'(stall), 32'd0);
        chk("lw_mis_data", data_fetched, 32'h0);
        step(); #1;
        chk("lw_mis_valid", 32'(bus_valid), 32'd0);
        chk("lw_mis_hold", 32'(misaligned), 32'd1);
        read_enable = 1'b0; #1;
        chk("lw_mis_clear", 32'(misaligned), 32'd0);

        // LHU 0x302
        step(); read_enable = 1'b1; format = 3'b101; address = 32'h302; #1;
        chk("lhu_mis", 32'(misaligned), 32'd0);
        step(); read_enable = 1'b0; bus_ready = 1'b1; bus_read_data = 32'h8001_0000; #1;
        chk("lhu_be", 32'(bus_byte_enable), 32'b1100);
        step(); bus_ready = 1'b0; #1;
        chk("lhu_data", data_fetched, 32'h0000_8001);

        // LW timeout with TIMEOUT_CYCLES=4
        step(); read_enable = 1'b1; format = 3'b010; address = 32'h400; #1;
        for (int i = 0; i < 4; i++) begin
            step(); read_enable = 1'b0; #1;
            chk($sformatf("to_valid_%0d", i), 32'(bus_valid), 32'd1);
        end
        step(); #1;
        chk("to_done_valid", 32'(bus_valid), 32'd0);
        chk("to_err", 32'(bus_error), 32'd1);
        chk("to_data", data_fetched, 32'h0);
        chk("to_stall", 32'(stall), 32'd0);
        step(); #1;
        chk("to_err_clear", 32'(bus_error), 32'd0);
        chk("to_idle_valid", 32'(bus_valid), 32'd0);

        // Both enables -> write; then reset mid-REQUEST
        step(); read_enable = 1'b1; write_enable = 1'b1; format = 3'b010; address = 32'h500; write_data = 32'h1234_5678; #1;
        step(); read_enable = 1'b0; write_enable = 1'b0; #1;
        chk("both_write", 32'(bus_write), 32'd1);
        chk("both_wdata", bus_write_data, 32'h1234_5678);
        chk("both_be", 32'(bus_byte_enable), 32'b1111);
        chk("both_valid", 32'(bus_valid), 32'd1);
        reset = 1'b0; #1;
        chk("arst_valid", 32'(bus_valid), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        step(); #1;
        chk("arst_err", 32'(bus_error), 32'd0);
        chk("arst_addr", bus_address, 32'h0);

        // First access after release is taken on the first edge
        step(); reset = 1'b1; read_enable = 1'b1; format = 3'b000; address = 32'h601; #1;
        step(); read_enable = 1'b0; bus_ready = 1'b1; bus_read_data = 32'h0000_7F00; #1;
        chk("post_rst_valid", 32'(bus_valid), 32'd1);
        chk("post_rst_be", 32'(bus_byte_enable), 32'b0010);
        chk("post_rst_err", 32'(bus_error), 32'd0);
        step(); bus_ready = 1'b0; #1;
        chk("post_rst_data", data_fetched, 32'h0000_007F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
